// File: rtl/pipeline_ctrl_pkg.sv
// Shared codes, state type and sizing helper for the pipeline hazard unit.
// Optional feature macro used by the unit: FORWARDING_EN.
package pipeline_ctrl_pkg;

   localparam logic [3:0] ITYPE_CALL  = 4'h6;
   localparam logic [3:0] ITYPE_RETID = 4'h7;
   localparam logic [3:0] ITYPE_RETIE = 4'h8;
   localparam logic [3:0] ITYPE_RET   = 4'h9;

   typedef enum logic [2:0] {
      S_RUN,
      S_RAW,
      S_FLUSH,
      S_INT,
      S_RESET
   } hazard_state_t;

   function automatic int max_depth(int a, int b, int c, int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/pipeline_hazard_unit_raw_detect.sv
// Per-port read-address compare against a single destination register.
// Returns the per-port hit vector and its OR.
module raw_detect #(
   parameter int NUM_RD = 2,
   parameter int REG_AW = 5
) (
   input  logic [NUM_RD*REG_AW-1:0] addr,
   input  logic [NUM_RD-1:0]        en,
   input  logic [REG_AW-1:0]        dst,
   input  logic                     dst_en,
   output logic                     hit,
   output logic [NUM_RD-1:0]        hits
);

   always_comb begin
      hits = '0;
      for (int i = 0; i < NUM_RD; i++) begin
         hits[i] = dst_en && en[i] &&
                   (addr[i*REG_AW +: REG_AW] == dst);
      end
   end

   assign hit = |hits;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Hazard and flush sequencer between decode and fetch/PC.
// Define FORWARDING_EN to replace WB-hazard stalls with WB->decode forwarding.
module pipeline_hazard_unit
   import pipeline_ctrl_pkg::*;
#(
   parameter int REG_AW     = 5,
   parameter int NUM_RD     = 2,
   parameter int ITYPE_W    = 4,
   parameter int BR_FLUSH   = 2,
   parameter int CALL_FLUSH = 2,
   parameter int INT_FLUSH  = 3,
   parameter int RST_FLUSH  = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD*REG_AW-1:0] rd_addr,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [REG_AW-1:0]        reg_ex,
   input  logic                     reg_ex_en,
   input  logic [REG_AW-1:0]        reg_wb,
   input  logic                     reg_wb_en,
   input  logic [ITYPE_W-1:0]       instr_type,
   input  logic                     branch_taken,
   input  logic                     interrupt,
   input  logic                     interrupt_flag,
   output logic                     imem_addr_mux,
   output logic                     fetch_latch_stall,
   output logic                     dec_nop,
   output logic                     dec_int,
   output logic                     pc_inc,
   output logic                     pc_load,
   output logic                     pc_reset,
   output logic [NUM_RD-1:0]        fwd_sel
);

   localparam int MAXD  = max_depth(BR_FLUSH, CALL_FLUSH,
                                    INT_FLUSH, RST_FLUSH);
   localparam int CNT_W = $clog2(MAXD) + 1;

   localparam logic [CNT_W-1:0] BR_LD   = CNT_W'(BR_FLUSH - 1);
   localparam logic [CNT_W-1:0] CALL_LD = CNT_W'(CALL_FLUSH - 1);
   localparam logic [CNT_W-1:0] INT_LD  = CNT_W'(INT_FLUSH - 1);
   localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_FLUSH - 1);

   localparam logic [ITYPE_W-1:0] IT_CALL  = ITYPE_W'(ITYPE_CALL);
   localparam logic [ITYPE_W-1:0] IT_RETID = ITYPE_W'(ITYPE_RETID);
   localparam logic [ITYPE_W-1:0] IT_RETIE = ITYPE_W'(ITYPE_RETIE);
   localparam logic [ITYPE_W-1:0] IT_RET   = ITYPE_W'(ITYPE_RET);

   hazard_state_t    state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;

   logic              raw_ex, raw_wb, raw_wb_stall;
   logic [NUM_RD-1:0] hit_ex, hit_wb;
   logic              ret_det, call_det, run, int_acc;
   logic              stall_c, stall;

   raw_detect #(.NUM_RD(NUM_RD), .REG_AW(REG_AW)) u_ex (
      .addr   (rd_addr),
      .en     (rd_en),
      .dst    (reg_ex),
      .dst_en (reg_ex_en),
      .hit    (raw_ex),
      .hits   (hit_ex)
   );

   raw_detect #(.NUM_RD(NUM_RD), .REG_AW(REG_AW)) u_wb (
      .addr   (rd_addr),
      .en     (rd_en),
      .dst    (reg_wb),
      .dst_en (reg_wb_en),
      .hit    (raw_wb),
      .hits   (hit_wb)
   );

   assign ret_det  = (instr_type == IT_RETID) ||
                     (instr_type == IT_RETIE) ||
                     (instr_type == IT_RET);
   assign call_det = (instr_type == IT_CALL);
   assign run      = (state == S_RUN);
   assign int_acc  = interrupt && interrupt_flag && run;

`ifdef FORWARDING_EN
   logic unused_wb;
   assign unused_wb    = raw_wb;
   assign raw_wb_stall = 1'b0;
   // EX result is newer than WB, so an EX match suppresses forwarding
   assign fwd_sel = (hit_wb & ~hit_ex) & {NUM_RD{run && !reset}};
`else
   logic unused_hits;
   assign unused_hits  = ^{hit_ex, hit_wb};
   assign raw_wb_stall = raw_wb;
   assign fwd_sel      = '0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_RESET;
         cnt   <= RST_LD;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (int_acc) begin
         state_nxt = S_INT;
         cnt_nxt   = INT_LD;
      end else begin
         unique case (state)
            S_RUN: begin
               if (raw_ex) begin
                  state_nxt = S_RAW;
               end else if (call_det) begin
                  state_nxt = S_FLUSH;
                  cnt_nxt   = CALL_LD;
               end else if (branch_taken || ret_det) begin
                  state_nxt = S_FLUSH;
                  cnt_nxt   = BR_LD;
               end
            end
            S_RAW: state_nxt = S_RUN;
            default: begin
               if (cnt == '0) state_nxt = S_RUN;
               else           cnt_nxt   = cnt - 1'b1;
            end
         endcase
      end
   end

   assign stall_c = (run && (raw_ex || ret_det || raw_wb_stall)) ||
                    (state == S_RAW);
   assign stall   = stall_c && !reset;

   assign imem_addr_mux     = stall;
   assign fetch_latch_stall = stall;
   assign dec_int           = int_acc && !reset;
   assign pc_reset          = reset;

   // Interrupt vector load happens on the first S_INT cycle only
   assign pc_load = !reset &&
                    ((run && (branch_taken || ret_det)) ||
                     (state == S_INT && cnt == INT_LD));
   assign pc_inc  = !reset && !pc_load && !stall;
   assign dec_nop = reset || !run || stall || call_det ||
                    branch_taken || dec_int;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed and randomized bench for pipeline_hazard_unit.
// Honours FORWARDING_EN the same way as the design.
module tb_pipeline_hazard_unit;

   localparam int AW   = 5;
   localparam int NR   = 2;
   localparam int BRD  = 2;
   localparam int CALD = 2;
   localparam int INTD = 3;
   localparam int RSTD = 2;

   logic           clk = 1'b0;
   logic           reset;
   logic [NR*AW-1:0] rd_addr;
   logic [NR-1:0]  rd_en;
   logic [AW-1:0]  reg_ex, reg_wb;
   logic           reg_ex_en, reg_wb_en;
   logic [3:0]     instr_type;
   logic           branch_taken, interrupt, interrupt_flag;
   logic           imem_addr_mux, fetch_latch_stall, dec_nop, dec_int;
   logic           pc_inc, pc_load, pc_reset;
   logic [NR-1:0]  fwd_sel;

   int checks   = 0;
   int failures = 0;

   // model: 0 run, 1 raw, 2 flush, 3 interrupt, 4 reset; left = cycles remaining
   int m_mode = 4;
   int m_left = RSTD;
   logic [8:0] last_o;

   always #5 clk = ~clk;

   pipeline_hazard_unit dut (
      .clk               (clk),
      .reset             (reset),
      .rd_addr           (rd_addr),
      .rd_en             (rd_en),
      .reg_ex            (reg_ex),
      .reg_ex_en         (reg_ex_en),
      .reg_wb            (reg_wb),
      .reg_wb_en         (reg_wb_en),
      .instr_type        (instr_type),
      .branch_taken      (branch_taken),
      .interrupt         (interrupt),
      .interrupt_flag    (interrupt_flag),
      .imem_addr_mux     (imem_addr_mux),
      .fetch_latch_stall (fetch_latch_stall),
      .dec_nop           (dec_nop),
      .dec_int           (dec_int),
      .pc_inc            (pc_inc),
      .pc_load           (pc_load),
      .pc_reset          (pc_reset),
      .fwd_sel           (fwd_sel)
   );

   task automatic chk(string tag, logic [8:0] o, logic [8:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic model(output logic [8:0] o, output int nm, output int nl);
      bit rex, rwb, ret, call, run, st, ld, di, inc, nop;
      logic [NR-1:0] fw;
      logic [AW-1:0] a;
      rex = 0; rwb = 0; fw = '0;
      run = (m_mode == 0);
      for (int i = 0; i < NR; i++) begin
         a = rd_addr[i*AW +: AW];
         if (rd_en[i] && reg_ex_en && a == reg_ex) rex = 1;
         if (rd_en[i] && reg_wb_en && a == reg_wb) rwb = 1;
`ifdef FORWARDING_EN
         if (rd_en[i] && reg_wb_en && a == reg_wb &&
             !(reg_ex_en && a == reg_ex) && run && !reset)
            fw[i] = 1'b1;
`endif
      end
      ret  = instr_type inside {4'h7, 4'h8, 4'h9};
      call = (instr_type == 4'h6);
`ifdef FORWARDING_EN
      st = (run && (rex || ret)) || m_mode == 1;
`else
      st = (run && (rex || ret || rwb)) || m_mode == 1;
`endif
      di  = interrupt && interrupt_flag && run;
      ld  = (run && (branch_taken || ret)) ||
            (m_mode == 3 && m_left == INTD);
      inc = !ld && !st;
      nop = !run || st || call || branch_taken || di;
      if (reset) o = {7'b0010001, 2'b00};
      else       o = {st, st, nop, di, inc, ld, 1'b0, fw};
      nm = m_mode; nl = m_left;
      if (reset) begin
         nm = 4; nl = RSTD;
      end else if (di) begin
         nm = 3; nl = INTD;
      end else if (run) begin
         if (rex)                     nm = 1;
         else if (call)               begin nm = 2; nl = CALD; end
         else if (branch_taken || ret) begin nm = 2; nl = BRD; end
      end else if (m_mode == 1) begin
         nm = 0;
      end else if (m_left <= 1) begin
         nm = 0;
      end else begin
         nl = m_left - 1;
      end
   endtask

   task automatic cyc(string tag);
      logic [8:0] e;
      int nm, nl;
      @(negedge clk);
      model(e, nm, nl);
      last_o = {imem_addr_mux, fetch_latch_stall, dec_nop, dec_int,
                pc_inc, pc_load, pc_reset, fwd_sel};
      chk(tag, last_o, e);
      @(posedge clk);
      m_mode = nm;
      m_left = nl;
      #1;
   endtask

   task automatic idle();
      reset = 0; rd_addr = '0; rd_en = '0;
      reg_ex = '0; reg_ex_en = 0; reg_wb = '0; reg_wb_en = 0;
      instr_type = 4'h0; branch_taken = 0;
      interrupt = 0; interrupt_flag = 0;
   endtask

   initial begin
      idle();
      reset = 1;
      cyc("reset_hold");
      chk("pc_reset_in_reset", 9'(last_o[2]), 9'd1);
      reset = 0;
      cyc("rst_flush1");
      chk("rst_nop1", 9'(last_o[6]), 9'd1);
      cyc("rst_flush2");
      chk("rst_nop2", 9'(last_o[6]), 9'd1);
      cyc("rst_run");
      chk("rst_pc_inc", 9'(last_o[4]), 9'd1);

      rd_addr = {5'd0, 5'd5}; rd_en = 2'b01;
      reg_ex = 5'd5; reg_ex_en = 1;
      cyc("raw_hit");
      chk("raw_stall1", {7'b0, last_o[8], last_o[4]}, 9'b10);
      idle();
      cyc("raw_state");
      chk("raw_stall2", {7'b0, last_o[8], last_o[4]}, 9'b10);
      cyc("raw_resume");
      chk("raw_inc", 9'(last_o[4]), 9'd1);

      branch_taken = 1;
      cyc("br_take");
      chk("br_load", 9'(last_o[3]), 9'd1);
      idle();
      cyc("br_fl1");
      cyc("br_fl2");
      chk("br_fl2_nop", 9'(last_o[6]), 9'd1);
      cyc("br_resume");
      chk("br_inc", {7'b0, last_o[6], last_o[4]}, 9'b01);

      instr_type = 4'h6; branch_taken = 1;
      cyc("call_br");
      chk("call_load", 9'(last_o[3]), 9'd1);
      idle();
      cyc("call_fl1");
      cyc("call_fl2");
      cyc("call_resume");

      branch_taken = 1;
      cyc("int_br");
      branch_taken = 0; interrupt = 1; interrupt_flag = 1;
      cyc("int_pend1");
      chk("int_pend1_dint", 9'(last_o[5]), 9'd0);
      cyc("int_pend2");
      cyc("int_accept");
      chk("int_dint", 9'(last_o[5]), 9'd1);
      interrupt = 0;
      cyc("int_load");
      chk("int_pcload", 9'(last_o[3]), 9'd1);
      cyc("int_fl2");
      cyc("int_fl3");
      chk("int_fl3_nop", 9'(last_o[6]), 9'd1);
      cyc("int_resume");
      idle();

      rd_addr = {5'd9, 5'd0}; rd_en = 2'b10;
      reg_wb = 5'd9; reg_wb_en = 1;
      cyc("wb_hit");
`ifdef FORWARDING_EN
      chk("wb_fwd", {6'b0, last_o[8], last_o[1:0]}, 9'b010);
`else
      chk("wb_stall", {6'b0, last_o[8], last_o[1:0]}, 9'b100);
`endif
      idle();
      cyc("wb_after");

      for (int n = 0; n < 600; n++) begin
         reset = ($urandom_range(0, 59) == 0);
         rd_addr = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
         rd_en = 2'($urandom);
         reg_ex = 5'($urandom_range(0, 3));
         reg_ex_en = ($urandom_range(0, 2) == 0);
         reg_wb = 5'($urandom_range(0, 3));
         reg_wb_en = ($urandom_range(0, 1) == 0);
         instr_type = ($urandom_range(0, 3) == 0) ?
                      4'($urandom_range(6, 9)) : 4'($urandom);
         branch_taken = ($urandom_range(0, 5) == 0);
         interrupt = ($urandom_range(0, 7) == 0);
         interrupt_flag = ($urandom_range(0, 3) != 0);
         cyc("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
